// File: rtl/alu_md_pkg.sv
// Shared encodings for the EX-stage ALU decoder and the M-extension sequencer.
package alu_md_pkg;

  localparam int OPW = 11;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;

  localparam logic [4:0] ALUC_ADD    = 5'b00000;
  localparam logic [4:0] ALUC_RTYPE  = 5'b00001;
  localparam logic [4:0] ALUC_ITYPE  = 5'b00010;
  localparam logic [4:0] ALUC_BRANCH = 5'b00100;
  localparam logic [4:0] ALUC_LUI    = 5'b01000;
  localparam logic [4:0] ALUC_MISC   = 5'b10000;

  typedef logic [1:0] md_state_t;
  localparam md_state_t ST_IDLE = 2'd0;
  localparam md_state_t ST_MUL  = 2'd1;
  localparam md_state_t ST_DIV  = 2'd2;
  localparam md_state_t ST_DONE = 2'd3;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  function automatic logic [OPW-1:0] op_onehot(input logic [3:0] idx);
    logic [OPW-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/alu_md_sequencer_if.sv
// EX-stage <-> M-op sequencer request/response bundle.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid must not depend on ready, and payload is held stable while valid waits for ready.
interface alu_md_sequencer_if #(
  parameter int XLEN = 32
);
  logic            md_req_valid;
  logic            md_req_ready;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            md_busy;
  logic            md_resp_valid;
  logic            md_resp_ready;
  logic [XLEN-1:0] md_result;

  modport master (
    output md_req_valid, src_a, src_b, flush, md_resp_ready,
    input  md_req_ready, md_busy, md_resp_valid, md_result
  );

  modport slave (
    input  md_req_valid, src_a, src_b, flush, md_resp_ready,
    output md_req_ready, md_busy, md_resp_valid, md_result
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational decode of ALU op class + instruction fields into a one-hot OpControl.
module alu_op_decode
  import alu_md_pkg::*;
(
  input  logic [4:0]     ALUControl,
  input  logic [2:0]     func3,
  input  logic           instr30,
  input  logic           instr25,
  output logic [OPW-1:0] OpControl
);

  logic [3:0] alu_op;
  logic       r_type;

  assign r_type = (ALUControl == ALUC_RTYPE);

  always_comb begin
    alu_op = OP_ADD;
    case (ALUControl)
      ALUC_RTYPE, ALUC_ITYPE: begin
        case (func3)
          3'd0: alu_op = (r_type && instr30) ? OP_SUB : OP_ADD;
          3'd1: alu_op = OP_SLL;
          3'd2: alu_op = OP_SLT;
          3'd3: alu_op = OP_SLTU;
          3'd4: alu_op = OP_XOR;
          3'd5: alu_op = instr30 ? OP_SRA : OP_SRL;
          3'd6: alu_op = OP_OR;
          3'd7: alu_op = OP_AND;
        endcase
        // M-ops never write back through the single-cycle ALU.
        if (r_type && instr25) alu_op = OP_ADD;
      end
      ALUC_BRANCH: alu_op = OP_SUB;
      ALUC_LUI:    alu_op = OP_PASSB;
      default:     alu_op = OP_ADD;
    endcase
  end

  assign OpControl = op_onehot(alu_op);

endmodule

// File: rtl/alu_md_sequencer.sv
// EX-stage ALU controller: one-hot op decode plus an iterative RV32M/RV64M multiply/divide engine.
module alu_md_sequencer
  import alu_md_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = alu_md_pkg::OPW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           ALUControl,
  input  logic [2:0]           func3,
  input  logic                 instr30,
  input  logic                 instr25,
  output logic [OPW-1:0]       OpControl,
  alu_md_sequencer_if.slave    md,
  output md_state_t            dbg_state
);

  localparam int CW = $clog2(XLEN) + 1;

  md_state_t         state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic              neg_r;

  alu_op_decode u_dec (
    .ALUControl (ALUControl),
    .func3      (func3),
    .instr30    (instr30),
    .instr25    (instr25),
    .OpControl  (OpControl)
  );

  logic            is_md, accept;
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  assign is_md  = (ALUControl == ALUC_RTYPE) && instr25;
  assign accept = md.md_req_valid && (state == ST_IDLE) && is_md && !md.flush;

  // Signedness per func3: MULH both, MULHSU rs1 only, DIV/REM both; the rest unsigned.
  assign a_sgn = func3[2] ? ~func3[0] : (func3[1:0] == 2'b01 || func3[1:0] == 2'b10);
  assign b_sgn = func3[2] ? ~func3[0] : (func3[1:0] == 2'b01);
  assign a_neg = a_sgn && md.src_a[XLEN-1];
  assign b_neg = b_sgn && md.src_b[XLEN-1];
  assign a_mag = a_neg ? (~md.src_a + 1'b1) : md.src_a;
  assign b_mag = b_neg ? (~md.src_b + 1'b1) : md.src_b;

  assign div_zero = func3[2] && (md.src_b == '0);
  assign div_ovf  = func3[2] && !func3[0] && (&md.src_b) &&
                    (md.src_a == {1'b1, {(XLEN-1){1'b0}}});
  assign special_res = div_zero ? (func3[1] ? md.src_a : '1)
                                : (func3[1] ? '0 : md.src_a);

  // Shift-add step: multiplier sits in the low half and shifts out as the product grows.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nx, mul_fin;
  logic [XLEN-1:0]   mul_res;

  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
  assign mul_nx  = {mul_sum, acc[XLEN-1:1]};
  assign mul_fin = neg_q ? (~mul_nx + 1'b1) : mul_nx;
  assign mul_res = (f3_q == F3_MUL) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];

  // Restoring step: remainder in the high half, dividend/quotient in the low half.
  logic [XLEN:0]     div_sh, div_tr;
  logic              div_ok;
  logic [2*XLEN-1:0] div_nx;
  logic [XLEN-1:0]   q_fin, r_fin, div_res;

  assign div_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_tr  = div_sh - {1'b0, opnd};
  assign div_ok  = !div_tr[XLEN];
  assign div_nx  = {(div_ok ? div_tr[XLEN-1:0] : div_sh[XLEN-1:0]), acc[XLEN-2:0], div_ok};
  assign q_fin   = neg_q ? (~div_nx[XLEN-1:0] + 1'b1) : div_nx[XLEN-1:0];
  assign r_fin   = neg_r ? (~div_nx[2*XLEN-1:XLEN] + 1'b1) : div_nx[2*XLEN-1:XLEN];
  assign div_res = f3_q[1] ? r_fin : q_fin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      acc          <= '0;
      opnd         <= '0;
      f3_q         <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      md.md_result <= '0;
    end else if (md.flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            f3_q  <= func3;
            cnt   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (div_zero || div_ovf) begin
              state        <= ST_DONE;
              md.md_result <= special_res;
            end else if (func3[2]) begin
              state <= ST_DIV;
              acc   <= {{XLEN{1'b0}}, a_mag};
              opnd  <= b_mag;
            end else begin
              state <= ST_MUL;
              acc   <= {{XLEN{1'b0}}, b_mag};
              opnd  <= a_mag;
            end
          end
        end
        ST_MUL: begin
          acc <= mul_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) begin
            state        <= ST_DONE;
            md.md_result <= mul_res;
          end
        end
        ST_DIV: begin
          acc <= div_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) begin
            state        <= ST_DONE;
            md.md_result <= div_res;
          end
        end
        default: begin
          if (md.md_resp_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign md.md_req_ready  = (state == ST_IDLE);
  assign md.md_resp_valid = (state == ST_DONE);
  assign md.md_busy       = is_md && md.md_req_valid && !((state == ST_DONE) && md.md_resp_ready);
  assign dbg_state        = state;

endmodule

// File: tb/tb_alu_md_sequencer.sv
// Bench for alu_md_sequencer: transaction-level model with per-cycle output compare.
module tb_alu_md_sequencer;
  localparam int XLEN = 32;
  localparam int OPW  = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      ALUControl;
  logic [2:0]      func3;
  logic            instr30;
  logic            instr25;
  logic [OPW-1:0]  OpControl;
  logic [1:0]      dbg_state;

  alu_md_sequencer_if #(.XLEN(XLEN)) md ();

  alu_md_sequencer #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ALUControl (ALUControl),
    .func3      (func3),
    .instr30    (instr30),
    .instr25    (instr25),
    .OpControl  (OpControl),
    .md         (md),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected ALU op from the decode rules.
  function automatic logic [OPW-1:0] ref_op(input logic [4:0] c, input logic [2:0] f3,
                                            input logic i30, input logic i25);
    int tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int n;
    logic [OPW-1:0] one;
    n = 0;
    if (c == 5'b00100) n = 1;
    else if (c == 5'b01000) n = 10;
    else if ((c == 5'b00001 && !i25) || c == 5'b00010) begin
      n = tab[f3];
      if (f3 == 3'd5 && i30) n = 7;
      if (f3 == 3'd0 && i30 && c == 5'b00001) n = 1;
    end
    one = '0;
    one[n] = 1'b1;
    return one;
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic [63:0] p;
    logic signed [31:0] qa, qb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    qa = a;
    qb = b;
    p = '0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return qa / qb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return qa % qb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Transaction model: an op is idle, counting down to its result, or waiting on WB.
  logic [XLEN-1:0] exp_q[$];
  logic m_busy, m_done;
  int   m_wait;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_wait <= 0;
      exp_q.delete();
    end else if (md.flush) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      exp_q.delete();
    end else if (m_done) begin
      if (md.md_resp_ready) begin
        m_done <= 1'b0;
        void'(exp_q.pop_front());
      end
    end else if (m_busy) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
    end else if (md.md_req_valid && ALUControl == 5'b00001 && instr25) begin
      exp_q.push_back(md_ref(func3, md.src_a, md.src_b));
      if (is_special(func3, md.src_a, md.src_b)) m_done <= 1'b1;
      else begin
        m_busy <= 1'b1;
        m_wait <= XLEN;
      end
    end
  end

  always @(negedge clk) begin
    logic is_md_now;
    is_md_now = (ALUControl == 5'b00001) && instr25;
    check("opcontrol", OpControl, ref_op(ALUControl, func3, instr30, instr25));
    check("onehot", $countones(OpControl), 1);
    check("req_ready", md.md_req_ready, !(m_busy || m_done));
    check("resp_valid", md.md_resp_valid, m_done);
    check("busy", md.md_busy, is_md_now && md.md_req_valid && !(m_done && md.md_resp_ready));
    if (m_done && exp_q.size() > 0) check("result", md.md_result, exp_q[0]);
  end

  // Issue one M-op, hold WB off for `hold` cycles, then retire it. Enter/leave at posedge+2.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output int lat, output logic [31:0] res);
    ALUControl = 5'b00001;
    instr25 = 1'b1;
    instr30 = 1'b0;
    func3 = f3;
    md.src_a = a;
    md.src_b = b;
    md.md_req_valid = 1'b1;
    md.md_resp_ready = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (md.md_resp_valid) break;
    end
    if (!md.md_resp_valid) check("resp_timeout", 0, 1);
    res = md.md_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_result", md.md_result, res);
      check("hold_busy", md.md_busy, 1);
      check("hold_ready", md.md_req_ready, 0);
      check("hold_valid", md.md_resp_valid, 1);
    end
    #1;
    md.md_resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("retire_idle", md.md_req_ready, 1);
    #1;
    md.md_req_valid = 1'b0;
    md.md_resp_ready = 1'b0;
    instr25 = 1'b0;
  endtask

  task automatic directed(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                          input int hold);
    int lat;
    logic [31:0] res;
    run_op(f3, a, b, hold, lat, res);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_res"}, res, exp_res);
  endtask

  initial begin
    logic [4:0] classes[6] = '{5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
    int lat;
    logic [31:0] res, a, b;
    logic [2:0] f3;

    rst = 1'b1;
    ALUControl = '0; func3 = '0; instr30 = 1'b0; instr25 = 1'b0;
    md.md_req_valid = 1'b0; md.src_a = '0; md.src_b = '0;
    md.flush = 1'b0; md.md_resp_ready = 1'b0;
    #3;
    check("rst_req_ready", md.md_req_ready, 1);
    check("rst_resp_valid", md.md_resp_valid, 0);
    check("rst_result", md.md_result, 0);
    check("rst_busy", md.md_busy, 0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;

    // Decode sweep with non-M requests that must never be accepted.
    foreach (classes[ci]) begin
      for (int f = 0; f < 8; f++) begin
        for (int i = 0; i < 2; i++) begin
          ALUControl = classes[ci];
          func3 = 3'(f);
          instr30 = i[0];
          instr25 = 1'b0;
          md.md_req_valid = 1'($urandom_range(0, 1));
          @(posedge clk); #2;
        end
      end
    end
    md.md_req_valid = 1'b0;
    ALUControl = 5'b00001; func3 = 3'd5; instr30 = 1'b1; #1;
    check("dec_sra", OpControl, 11'h080);
    ALUControl = 5'b00010; func3 = 3'd0; instr30 = 1'b1; #1;
    check("dec_addi", OpControl, 11'h001);
    ALUControl = 5'b01000; func3 = 3'd3; instr30 = 1'b0; #1;
    check("dec_lui", OpControl, 11'h400);
    @(posedge clk); #2;

    directed("mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 33, 32'hFFFF_FFEB, 0);
    directed("mulhu",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 0);
    directed("div",     3'd4, 32'hFFFF_FFEC,  32'd3,         33, 32'hFFFF_FFFA, 0);
    directed("rem",     3'd6, 32'hFFFF_FFEC,  32'd3,         33, 32'hFFFF_FFFE, 0);
    directed("divu",    3'd5, 32'd100,        32'd7,         33, 32'd14,        0);
    directed("divu_z",  3'd5, 32'h1234,       32'd0,         1,  32'hFFFF_FFFF, 0);
    directed("rem_ovf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 1,  32'h0,         0);
    directed("div_ovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 1,  32'h8000_0000, 0);
    directed("mul_hold", 3'd1, 32'hFFFF_FFF0, 32'd5,         33, 32'hFFFF_FFFF, 5);

    // Flush ten cycles into a DIV, then a MUL must go straight in.
    ALUControl = 5'b00001; instr25 = 1'b1; func3 = 3'd4;
    md.src_a = 32'd1000; md.src_b = 32'd7; md.md_req_valid = 1'b1;
    repeat (10) @(posedge clk);
    #2; md.flush = 1'b1;
    @(posedge clk); #1;
    check("flush_no_valid", md.md_resp_valid, 0);
    check("flush_idle", md.md_req_ready, 1);
    #1; md.flush = 1'b0;
    directed("mul_after_flush", 3'd0, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFEB, 0);

    // A request coincident with flush is dropped.
    ALUControl = 5'b00001; instr25 = 1'b1; func3 = 3'd0;
    md.md_req_valid = 1'b1; md.flush = 1'b1;
    @(posedge clk); #1;
    check("flush_blocks_accept", md.md_req_ready, 1);
    #1; md.flush = 1'b0; md.md_req_valid = 1'b0;
    @(posedge clk); #2;

    // Async reset ten cycles into a DIV.
    func3 = 3'd4; md.src_a = 32'd999; md.src_b = 32'd4; md.md_req_valid = 1'b1;
    repeat (10) @(posedge clk);
    #2; rst = 1'b1; md.md_req_valid = 1'b0;
    #1;
    check("arst_req_ready", md.md_req_ready, 1);
    check("arst_resp_valid", md.md_resp_valid, 0);
    check("arst_result", md.md_result, 0);
    check("arst_busy", md.md_busy, 0);
    @(posedge clk); #2; rst = 1'b0;
    @(posedge clk); #2;

    // Randomized ops, occasional flushes, and non-M traffic in between.
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)) - 32'd150; b = 32'($urandom_range(1, 20)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      if ($urandom_range(0, 5) == 0) begin
        int k;
        k = $urandom_range(0, 40);
        ALUControl = 5'b00001; instr25 = 1'b1; func3 = f3;
        md.src_a = a; md.src_b = b; md.md_req_valid = 1'b1;
        repeat (k) @(posedge clk);
        if (k == 0) #0; else #2;
        md.flush = 1'b1;
        @(posedge clk); #2;
        md.flush = 1'b0; md.md_req_valid = 1'b0;
      end else begin
        run_op(f3, a, b, $urandom_range(0, 3), lat, res);
        check("rand_latency", lat, is_special(f3, a, b) ? 1 : XLEN + 1);
      end
      repeat ($urandom_range(0, 3)) begin
        ALUControl = 5'($urandom);
        func3 = 3'($urandom);
        instr30 = 1'($urandom);
        instr25 = (ALUControl == 5'b00001) ? 1'b0 : 1'($urandom);
        md.md_req_valid = 1'($urandom);
        @(posedge clk); #2;
      end
      md.md_req_valid = 1'b0;
      instr25 = 1'b0;
    end

    @(posedge clk); #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_md_sequencer.md
Name: alu_md_sequencer

Overview:
Next-generation ALU controller for the RISC-V core: XLEN-parametrised, with RV32M/RV64M support.
- Decodes ALUControl class, func3, instr30 and instr25 into a one-hot OpControl for the single-cycle ALU.
- Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on an internal iterative shift-add/restoring engine.
- Sits in EX stage; stalls the pipeline through a valid/ready handshake while an M-op is in flight.

Parameters:
XLEN, 32, operand/result width (32 or 64)
OPW, 11, OpControl width (fixed by package encoding)

Ports:
clk  input  1  core clock; all state on rising edge
rst  input  1  reset, asynchronous, active-high
ALUControl  input  5  one-hot op class from main decoder
func3  input  3  instr[14:12]
instr30  input  1  instr[30]
instr25  input  1  instr[25] (M-extension select)
OpControl  output  OPW  one-hot single-cycle ALU op (combinational)
md_req_valid  input  1  EX holds an M-op with operands valid
md_req_ready  output  1  engine idle, accepts request
src_a  input  XLEN  rs1 value
src_b  input  XLEN  rs2 value
flush  input  1  kill in-flight M-op (branch/trap)
md_busy  output  1  stall request to hazard unit
md_resp_valid  output  1  result valid
md_resp_ready  input  1  WB accepts result
md_result  output  XLEN  M-op result

Behaviour:
- One clock domain; reset asynchronous, active-high.
- Reset values: state IDLE, md_resp_valid 0, md_result 0, counter 0, md_busy 0, md_req_ready 1.
- OpControl bit order (package): 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB. Exactly one bit set for any input.
- ALUControl decode:
  - 00000: ADD (load/store/auipc/jal).
  - 00001 (R-type): func3 select; instr30 chooses SUB over ADD at func3=0 and SRA over SRL at func3=5. If instr25=1, OpControl=ADD (don't-care, no ALU writeback).
  - 00010 (I-type): as R-type, but instr30 honoured only at func3=5 (SRAI); func3=0 is always ADD.
  - 00100: SUB (branch compare).
  - 01000: PASSB (LUI).
  - 10000, and any non-one-hot value: ADD.
- M-op is_md = (ALUControl==00001) & instr25. Accepted when md_req_valid & md_req_ready & is_md. Operands and func3 are captured that cycle.
- FSM states IDLE, MUL, DIV, DONE:
  - IDLE->MUL on func3[2]=0; IDLE->DIV on func3[2]=1.
  - MUL: XLEN iterations, one bit per cycle, on 2XLEN accumulator with sign-corrected operands per func3. Go to DONE at counter==XLEN-1.
  - DIV: XLEN iterations of restoring division on magnitudes. Result sign is fixed in DONE entry.
  - Div-by-zero: IDLE->DONE directly. Quotient = all ones; remainder = src_a.
  - Signed overflow (src_a = min negative, src_b = -1, DIV/REM): IDLE->DONE directly. Quotient = src_a; remainder = 0.
  - DONE: md_resp_valid=1, md_result held stable until md_resp_ready; then ->IDLE.
- Latency from accept to md_resp_valid:
  - MUL/DIV: XLEN+1 cycles (33 at XLEN=32).
  - Special cases: 1 cycle.
- MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
- md_req_ready = (state==IDLE).
- md_busy = is_md & md_req_valid & ~(state==DONE & md_resp_ready).
- flush: any state ->IDLE next edge; md_resp_valid drops; result discarded. flush in the same cycle as a request means the request is not accepted. flush has priority over md_resp_ready.
- Non-M request: never accepted, md_busy=0.
- Counter width is $clog2(XLEN)+1 and never wraps; it is cleared on every accept.
- Async reset mid-operation: immediate IDLE, outputs to reset values.

Decomposition:
- Package alu_md_pkg:
  - OpControl bit-index localparams and OPW.
  - ALUControl class encodings.
  - FSM state enum (2-bit).
  - func3 M-op codes (MUL=0..REMU=7).
- Sub-module alu_op_decode: the pure combinational OpControl decode. The sequencer instantiates it and keeps the FSM, counter and datapath.

Test Plan:
1. Sweep ALUControl over {00000, 00001, 00010, 00100, 01000, 10000} x func3 0..7 x instr30 0/1, instr25=0 -> exactly one OpControl bit set, e.g. 00001/func3=5/instr30=1 -> bit7 (SRA); 00010/func3=0/instr30=1 -> bit0 (ADD); 01000 -> bit10.
2. MUL, src_a=7, src_b=-3 -> md_resp_valid at cycle 33, result 0xFFFFFFEB. MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
3. DIV, -20 / 3 -> 0xFFFFFFFA. REM, same operands -> 0xFFFFFFFE. DIVU, 100 / 7 -> 14. All at cycle 33.
4. DIVU x/0 with x=0x1234 -> 0xFFFFFFFF after 1 cycle. REM 0x80000000 / -1 -> 0 after 1 cycle. DIV 0x80000000 / -1 -> 0x80000000 after 1 cycle.
5. Hold md_resp_ready=0 for 5 cycles in DONE -> md_result stable, md_busy=1, md_req_ready=0. Raise md_resp_ready -> IDLE next cycle.
6. Assert flush at cycle 10 of a DIV -> IDLE next edge, no md_resp_valid. A new MUL is then accepted immediately. Repeat the abort with async rst at cycle 10 -> all outputs at reset values without waiting for a clock edge.
